// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin burst arbiter sharing a 2:1 mux into a registered valid/ready stage
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             last0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic             last1,
  output logic             gnt1,
  output logic             sel,
  output logic             busy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             sel_q, sel_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             src, cur_req, cur_last, oth_req, space, beat, burst_end, pick;
  logic [WIDTH-1:0] cur_data;
  assign src       = (state_q == GRANT1);
  assign cur_req   = src ? req1 : req0;
  assign cur_last  = src ? last1 : last0;
  assign cur_data  = src ? data1 : data0;
  assign oth_req   = src ? req0 : req1;
  assign busy      = (state_q != IDLE);
  assign space     = !out_valid_q || out_ready;
  assign gnt0      = (state_q == GRANT0) && space;
  assign gnt1      = (state_q == GRANT1) && space;
  assign beat      = busy && cur_req && space;
  assign burst_end = busy && (!cur_req || (beat && (cur_last || cnt_q == CW'(MAX_BURST - 1))));
  assign pick      = (req0 && req1) ? prio_q : req1;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  // idle arbitration, burst hand-over to the other source, and output stage update
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    out_valid_d = beat || (out_valid_q && !out_ready);
    out_data_d  = beat ? cur_data : out_data_q;
    if (!busy) begin
      state_d = (req0 || req1) ? (pick ? GRANT1 : GRANT0) : IDLE;
      sel_d   = (req0 || req1) ? pick : sel_q;
    end else if (burst_end) begin
      prio_d  = !src;
      cnt_d   = '0;
      state_d = oth_req ? (src ? GRANT0 : GRANT1) : IDLE;
      sel_d   = oth_req ? !src : sel_q;
    end else begin
      cnt_d   = beat ? cnt_q + 1'b1 : cnt_q;
    end
  end
  // state and datapath registers, cleared asynchronously so an in-flight burst is dropped at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule
